// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a 4-bit universal shift register.
// Rotate/hold/load commands are queued in a small FIFO and expanded into
// N cycles of registered mux-select and parallel-data drive.
module shift_reg_sequencer #(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [3:0] CMD_CNT,
    input  logic [3:0] CMD_DATA,
    output logic       S1,
    output logic       S0,
    output logic       D3,
    output logic       D2,
    output logic       D1,
    output logic       D0,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] ROT_POS
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_ROTL = 2'b00;
    localparam logic [1:0] OP_ROTR = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // FIFO storage and bookkeeping; entry layout is {op, cnt, data}
    logic [9:0]       mem_q [DEPTH];
    logic [9:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_s, empty_s, push_s, pop_s;
    logic [9:0]       head_s;

    // Sequencer state
    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] rem_q, rem_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] rot_q, rot_d;

    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == '0);
    assign CMD_READY = !full_s && !RST;
    assign push_s    = CMD_VALID && CMD_READY;
    assign head_s    = mem_q[rd_ptr_q];

    assign {S1, S0}         = sel_q;
    assign {D3, D2, D1, D0} = data_q;
    assign BUSY             = busy_q;
    assign DONE             = done_q;
    assign ROT_POS          = rot_q;

    // FIFO next-state: a pop never frees a slot for a same-cycle push
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {CMD_OP, CMD_CNT, CMD_DATA};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1'b1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers with synchronous flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 10'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer next-state: pop in IDLE, drive the op for N cycles in EXEC
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        data_d  = data_q;
        done_d  = 1'b0;
        rot_d   = rot_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = OP_HOLD;
                if (!empty_s) begin
                    pop_s  = 1'b1;
                    op_d   = head_s[9:8];
                    sel_d  = head_s[9:8];
                    data_d = head_s[3:0];
                    if (head_s[9:8] == OP_LOAD) begin
                        rem_d = 4'd1;
                    end else if (head_s[7:4] == 4'd0) begin
                        rem_d = 4'd1;
                    end else begin
                        rem_d = head_s[7:4];
                    end
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rem_d = rem_q - 4'd1;
                case (op_q)
                    OP_ROTL: rot_d = rot_q + 2'd1;
                    OP_ROTR: rot_d = rot_q - 2'd1;
                    OP_LOAD: rot_d = 2'd0;
                    default: rot_d = rot_q;
                endcase
                if (rem_q == 4'd1) begin
                    sel_d   = OP_HOLD;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sel_d   = op_q;
                    state_d = EXEC;
                end
            end
            default: begin
                sel_d   = OP_HOLD;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == EXEC);
    end

    // Sequencer registers; reset abandons any in-flight command silently
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            rem_q   <= 4'd0;
            sel_q   <= OP_HOLD;
            data_q  <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rot_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rot_q   <= rot_d;
        end
    end

endmodule
